// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer controller and its MAC unit.
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INIT      = 3'd1,
      ST_INIT_WAIT = 3'd2,
      ST_RUN       = 3'd3,
      ST_DRAIN     = 3'd4
   } fc_state_e;

   localparam int FC_DW      = 8;
   localparam int FC_ADDR_DW = 5;
   localparam int FC_N_IN    = 8;
   localparam int FC_N_OUT   = 4;
   localparam int FC_ACT_AW  = 3;
   localparam int FC_ACC_DW  = 20;
   localparam int FC_OUT_AW  = 2;

   function automatic int fc_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed multiply-accumulate stage with first/last/index flags and a registered result port.
// Build with FC_RELU_EN defined to clamp negative results to zero before the output register.
module fc_mac_unit
   import fc_pkg::*;
#(
   parameter int DW     = FC_DW,
   parameter int ACC_DW = FC_ACC_DW,
   parameter int OUT_AW = FC_OUT_AW,
   parameter int N_OUT  = FC_N_OUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_en,
   input  logic              issue_first,
   input  logic              issue_last,
   input  logic [OUT_AW-1:0] issue_idx,
   input  logic [DW-1:0]     rom_dout,
   input  logic [DW-1:0]     act_data,
   output logic              final_pending,
   output logic              out_valid,
   output logic [OUT_AW-1:0] out_idx,
   output logic [ACC_DW-1:0] out_data
);

   logic                     v1;
   logic                     first1;
   logic                     last1;
   logic [OUT_AW-1:0]        idx1;
   logic signed [ACC_DW-1:0] acc;

   logic signed [2*DW-1:0]   w_ext;
   logic signed [2*DW-1:0]   a_ext;
   logic signed [2*DW-1:0]   prod;
   logic signed [ACC_DW-1:0] prod_ext;
   logic signed [ACC_DW-1:0] acc_next;
   logic signed [ACC_DW-1:0] result;

   // Operands are widened before the multiply so the full 2*DW signed product is kept.
   always_comb begin
      w_ext    = {{DW{rom_dout[DW-1]}}, rom_dout};
      a_ext    = {{DW{act_data[DW-1]}}, act_data};
      prod     = w_ext * a_ext;
      prod_ext = ACC_DW'(prod);
      acc_next = first1 ? prod_ext : acc + prod_ext;
`ifdef FC_RELU_EN
      result   = acc_next[ACC_DW-1] ? '0 : acc_next;
`else
      result   = acc_next;
`endif
   end

   assign final_pending = v1 && last1 && (idx1 == OUT_AW'(N_OUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         first1    <= 1'b0;
         last1     <= 1'b0;
         idx1      <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
      end else begin
         v1        <= issue_en;
         first1    <= issue_first;
         last1     <= issue_last;
         idx1      <= issue_idx;
         out_valid <= v1 && last1;
         if (v1) acc <= acc_next;
         if (v1 && last1) begin
            out_data <= result;
            out_idx  <= idx1;
         end
      end
   end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequences FC weight ROM initialisation, then streams weights/activations into the MAC unit.
// Optional FC_RELU_EN (see fc_mac_unit) clamps each neuron result at zero.
module fc_layer_ctrl
   import fc_pkg::*;
#(
   parameter int DW      = FC_DW,
   parameter int ADDR_DW = FC_ADDR_DW,
   parameter int N_IN    = FC_N_IN,
   parameter int N_OUT   = FC_N_OUT,
   parameter int ACT_AW  = FC_ACT_AW,
   parameter int ACC_DW  = FC_ACC_DW,
   parameter int OUT_AW  = FC_OUT_AW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               rom_initial_sig,
   input  logic               rom_init_ack,
   output logic               rom_RAenable,
   output logic [ADDR_DW-1:0] rom_addr,
   input  logic [DW-1:0]      rom_dout,
   output logic               act_rd_en,
   output logic [ACT_AW-1:0]  act_addr,
   input  logic [DW-1:0]      act_data,
   output logic               out_valid,
   output logic [OUT_AW-1:0]  out_idx,
   output logic [ACC_DW-1:0]  out_data
);

   fc_state_e         state;
   logic              init_done;
   logic [OUT_AW-1:0] o_cnt;
   logic              i_last;
   logic              o_last;
   logic              final_pending;

   // act_addr doubles as the input counter i; rom_addr simply counts o*N_IN+i.
   assign i_last = (act_addr == ACT_AW'(N_IN - 1));
   assign o_last = (o_cnt == OUT_AW'(N_OUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         init_done       <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         rom_initial_sig <= 1'b0;
         rom_RAenable    <= 1'b0;
         act_rd_en       <= 1'b0;
         rom_addr        <= '0;
         act_addr        <= '0;
         o_cnt           <= '0;
      end else begin
         rom_initial_sig <= 1'b0;
         done            <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (init_done) begin
                     state        <= ST_RUN;
                     rom_RAenable <= 1'b1;
                     act_rd_en    <= 1'b1;
                     rom_addr     <= '0;
                     act_addr     <= '0;
                     o_cnt        <= '0;
                  end else begin
                     state           <= ST_INIT;
                     rom_initial_sig <= 1'b1;
                  end
               end
            end
            ST_INIT: begin
               state <= ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
               if (rom_init_ack) begin
                  init_done    <= 1'b1;
                  state        <= ST_RUN;
                  rom_RAenable <= 1'b1;
                  act_rd_en    <= 1'b1;
                  rom_addr     <= '0;
                  act_addr     <= '0;
                  o_cnt        <= '0;
               end
            end
            ST_RUN: begin
               if (i_last && o_last) begin
                  state        <= ST_DRAIN;
                  rom_RAenable <= 1'b0;
                  act_rd_en    <= 1'b0;
               end else begin
                  rom_addr <= rom_addr + ADDR_DW'(1);
                  if (i_last) begin
                     act_addr <= '0;
                     o_cnt    <= o_cnt + OUT_AW'(1);
                  end else begin
                     act_addr <= act_addr + ACT_AW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               // done is raised to line up with the final out_valid, then IDLE follows.
               if (done) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (final_pending) begin
                  done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   fc_mac_unit #(
      .DW     (DW),
      .ACC_DW (ACC_DW),
      .OUT_AW (OUT_AW),
      .N_OUT  (N_OUT)
   ) u_mac (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_en      (rom_RAenable),
      .issue_first   (act_addr == '0),
      .issue_last    (i_last),
      .issue_idx     (o_cnt),
      .rom_dout      (rom_dout),
      .act_data      (act_data),
      .final_pending (final_pending),
      .out_valid     (out_valid),
      .out_idx       (out_idx),
      .out_data      (out_data)
   );

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl: ROM/activation models, address monitor and result scoreboard.
module tb_fc_layer_ctrl;
   import fc_pkg::*;

   localparam int DW = 8, ADDR_DW = 5, N_IN = 8, N_OUT = 4;
   localparam int ACT_AW = 3, ACC_DW = 20, OUT_AW = 2;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               busy;
   logic               done;
   logic               rom_initial_sig;
   logic               rom_init_ack = 1'b0;
   logic               rom_RAenable;
   logic [ADDR_DW-1:0] rom_addr;
   logic [DW-1:0]      rom_dout = '0;
   logic               act_rd_en;
   logic [ACT_AW-1:0]  act_addr;
   logic [DW-1:0]      act_data = '0;
   logic               out_valid;
   logic [OUT_AW-1:0]  out_idx;
   logic [ACC_DW-1:0]  out_data;

   fc_layer_ctrl #(
      .DW(DW), .ADDR_DW(ADDR_DW), .N_IN(N_IN), .N_OUT(N_OUT),
      .ACT_AW(ACT_AW), .ACC_DW(ACC_DW), .OUT_AW(OUT_AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rom_initial_sig(rom_initial_sig), .rom_init_ack(rom_init_ack),
      .rom_RAenable(rom_RAenable), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data),
      .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // memory models: ROM acks one cycle after initial_sig, both reads have 1-cycle latency
   logic signed [DW-1:0] rom_mem [N_IN*N_OUT];
   logic signed [DW-1:0] act_mem [2**ACT_AW];

   always @(posedge clk) begin
      rom_init_ack <= rom_initial_sig;
      if (rom_RAenable) rom_dout <= rom_mem[rom_addr];
      if (act_rd_en)    act_data <= act_mem[act_addr];
   end

   // scoreboard
   logic [ACC_DW-1:0] exp_q[$];
   logic [OUT_AW-1:0] idx_q[$];
   int n_vec = 0, n_err = 0;
   int exp_addr = 0, issue_cnt = 0, init_hi = 0, done_cnt = 0;
   bit ack_d = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ACC_DW-1:0] model(input int o);
      int s;
      s = 0;
      for (int i = 0; i < N_IN; i++) s += int'(rom_mem[o*N_IN+i]) * int'(act_mem[i]);
`ifdef FC_RELU_EN
      if (s < 0) s = 0;
`endif
      return ACC_DW'(s);
   endfunction

   task automatic push_expected();
      for (int o = 0; o < N_OUT; o++) begin
         exp_q.push_back(model(o));
         idx_q.push_back(OUT_AW'(o));
      end
   endtask

   // monitor: issue order, init handshake, results, done alignment
   always @(negedge clk) begin
      if (rst_n) begin
         if (ack_d) check("first_issue_after_ack", {rom_RAenable, rom_addr}, {1'b1, 5'd0});
         ack_d = rom_init_ack;
         if (rom_initial_sig) init_hi++;
         if (rom_RAenable) begin
            check("rom_addr", rom_addr, exp_addr[ADDR_DW-1:0]);
            check("act_addr", act_addr, exp_addr % N_IN);
            check("act_rd_en", act_rd_en, 1);
            check("busy_in_run", busy, 1);
            exp_addr++;
            issue_cnt++;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 0);
            else begin
               check("out_data", out_data, exp_q.pop_front());
               check("out_idx", out_idx, idx_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            check("done_with_last", {out_valid, out_idx}, {1'b1, 2'(N_OUT - 1)});
         end
      end else begin
         ack_d = 1'b0;
      end
   end

   // driver: one full layer run, optionally pulsing start while busy
   task automatic run_layer(input bit expect_init, input int mid_start_at);
      bit got;
      exp_addr = 0; issue_cnt = 0; init_hi = 0; done_cnt = 0;
      push_expected();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("busy_after_start", busy, 1);
      if (!expect_init) check("addr0_after_start", {rom_RAenable, rom_addr}, {1'b1, 5'd0});
      else              check("init_sig_after_start", rom_initial_sig, 1);
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(negedge clk);
         start = (mid_start_at >= 0 && issue_cnt == mid_start_at);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      check("done_seen", got, 1);
      check("issue_count", issue_cnt, N_IN * N_OUT);
      check("init_pulse_cycles", init_hi, expect_init ? 1 : 0);
      @(negedge clk);
      check("busy_cleared", busy, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      check("done_pulses", done_cnt, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {busy, done, rom_initial_sig, rom_RAenable, act_rd_en, out_valid}, 0);
      check({tag, "_addr"}, {rom_addr, act_addr, out_idx}, 0);
      check({tag, "_data"}, out_data, 0);
   endtask

   initial begin
      bit hit;
      rst_n = 1'b0;
      start = 1'b0;
      for (int a = 0; a < N_IN*N_OUT; a++) begin
         case (a % 4)
            0: rom_mem[a] = 8'sd1;
            1: rom_mem[a] = -8'sd3;
            2: rom_mem[a] = 8'sd3;
            default: rom_mem[a] = -8'sd3;
         endcase
      end
      for (int i = 0; i < 2**ACT_AW; i++) act_mem[i] = 8'sd1;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("idle");

      // first run goes through INIT; second reuses init_done
      run_layer(1'b1, -1);
      run_layer(1'b0, -1);

      // random operands with sign-extension extremes, start pulsed mid-run
      for (int a = 0; a < N_IN*N_OUT; a++) rom_mem[a] = DW'($urandom_range(0, 255));
      for (int i = 0; i < N_IN; i++) act_mem[i] = DW'($urandom_range(0, 255));
      for (int i = 0; i < N_IN; i++) rom_mem[3*N_IN+i] = -8'sd128;
      act_mem[0] = -8'sd128;
      act_mem[N_IN-1] = 8'sd127;
      run_layer(1'b0, 10);

      // reset during RUN at o=2, then a clean rerun including INIT
      exp_addr = 0; issue_cnt = 0;
      push_expected();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         if (rom_RAenable && rom_addr == 5'd18) hit = 1'b1;
         else @(negedge clk);
      end
      check("reached_o2", hit, 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrun_reset");
      exp_q.delete();
      idx_q.delete();
      @(negedge clk);
      check_all_zero("held_reset");
      rst_n = 1'b1;
      @(negedge clk);
      run_layer(1'b1, -1);
      repeat (4) @(negedge clk);
      check("no_stale_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fc_layer_ctrl.md
Name: fc_layer_ctrl

Overview:
Downstream consumer of the FC weight ROM (rom_fc): sequences ROM initialisation, then computes N_OUT fully-connected dot products of length N_IN.
- Drives ROM address/read-enable; weight for (neuron o, input i) lives at rom_addr = o*N_IN + i.
- Reads activations from an external activation buffer with matching 1-cycle read latency.
- Emits one signed accumulator result per output neuron on a valid strobe, feeding the classifier/argmax stage.

Parameters:
DW, 8, weight/activation width (signed)
ADDR_DW, 5, ROM address width
N_IN, 8, inputs per neuron (>=1)
N_OUT, 4, output neurons (>=1); N_IN*N_OUT <= 2**ADDR_DW
ACT_AW, 3, activation buffer address width (2**ACT_AW >= N_IN)
ACC_DW, 20, accumulator width (>= 2*DW + clog2(N_IN))
OUT_AW, 2, out_idx width (2**OUT_AW >= N_OUT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run the layer
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse with the last out_valid
rom_initial_sig  out  1  to ROM initial_sig
rom_init_ack  in  1  from ROM mem_initial_signal
rom_RAenable  out  1  to ROM RAenable
rom_addr  out  ADDR_DW  to ROM addr
rom_dout  in  DW  ROM data, signed, valid 1 cycle after rom_RAenable
act_rd_en  out  1  activation buffer read enable
act_addr  out  ACT_AW  activation index i
act_data  in  DW  activation, signed, valid 1 cycle after act_rd_en
out_valid  out  1  result strobe
out_idx  out  OUT_AW  neuron index of out_data
out_data  out  ACC_DW  signed dot product

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; internal init_done flag is cleared. Applies immediately, including mid-run; no partial result is emitted.
- FSM states: IDLE, INIT, INIT_WAIT, RUN, DRAIN.
- IDLE:
  - start=1 with init_done=0 -> INIT.
  - start=1 with init_done=1 -> RUN.
  - busy=1 from the cycle after start is accepted.
- INIT: rom_initial_sig=1 for exactly one cycle -> INIT_WAIT.
- INIT_WAIT: rom_initial_sig=0, RAenable=0. On rom_init_ack=1, set init_done -> RUN. Waits indefinitely otherwise.
- RUN issues one read per cycle, back to back, for N_IN*N_OUT cycles:
  - rom_RAenable=act_rd_en=1.
  - rom_addr=o*N_IN+i, act_addr=i.
  - i wraps 0..N_IN-1; o increments on wrap.
  - After the final issue (o=N_OUT-1, i=N_IN-1) -> DRAIN. rom_RAenable/act_rd_en drop to 0 the next cycle.
- Pipeline: issue at cycle k; at k+1 compute prod = sext(rom_dout)*sext(act_data) (2*DW signed). Accumulate acc <= first ? prod : acc+prod, where first/last/o are issue-time flags delayed 1 cycle.
- If last was set at k+1: out_valid=1 at k+2, out_data=acc, out_idx=o. out_valid is 0 otherwise; out_data/out_idx hold their last values.
- DRAIN: remains until the final out_valid. done=1 in that same cycle. busy=0 and IDLE from the next cycle.
- start while busy=1 is ignored.
- N_IN=1: every issue is both first and last; one result per cycle after 2-cycle latency.
- Accumulator wraps modulo 2**ACC_DW; no saturation.
- init_done persists across runs; only reset clears it.

Optional Feature:
FC_RELU_EN:
- Defined: out_data = (acc < 0) ? 0 : acc. Applied combinationally before the out_data register; latency unchanged.
- Undefined: out_data = raw signed acc.

Decomposition:
- Package fc_pkg: FSM state enum, default widths, a clog2 function.
- One sub-module fc_mac_unit: sign-extending multiplier + accumulator with first/last/idx pipeline flags and output register (plus the ReLU option).
- fc_layer_ctrl holds the FSM and the address counters.

Test Plan:
- rst_n low, then high, then start; ROM acks 1 cycle after rom_initial_sig -> rom_initial_sig high exactly 1 cycle; first rom_addr=0 issued the cycle after the ack; busy=1 throughout.
- ROM para=0, all activations=1, N_IN=8, N_OUT=4 -> out_idx0 gives out_data=-4 (weights 1,-3,3,-3,1,-3,3,-3); out_idx1 gives -4; 32 back-to-back issues; done coincides with out_idx=3.
- Same run compiled with FC_RELU_EN -> out_idx0 and out_idx1 give 0.
- Second start after done -> no rom_initial_sig pulse; rom_addr=0 on the cycle after start; results identical to the first run.
- start pulsed mid-RUN -> ignored; address sequence and results unchanged.
- rst_n asserted during RUN at o=2 -> all outputs 0 immediately; next start re-runs INIT; 4 results, no stale out_valid.
